keccak_chi_sched: RTL

- Sequences one masked chi(+iota) layer of Keccak-f[25*LANE_W] through a single external DOM chi S-box instance.
- Reads each 5-bit masked row from a shared state RAM and presents it to the S-box together with fresh randomness from a PRNG.
- Writes the S-box result back to the same address.
- Sits between the round controller, the state RAM and the S-box.

---
 rtl/keccak_chi_sched_if.sv | 38 +++
 rtl/keccak_chi_sched.sv | 118 +++++++++++
 2 files changed

// File: rtl/keccak_chi_sched_if.sv
// Bundle of the scheduler's controller, state-RAM, S-box and PRNG signals.
// The master modport is the scheduler side; the slave side is the surrounding system.
interface keccak_chi_sched_if #(
  parameter int SHARES = 2,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 6,
  parameter int RAND_W = (SHARES*SHARES-SHARES)/2*5
);
  logic                  StartxSI;
  logic [LANE_W-1:0]     RcxDI;
  logic                  BusyxSO;
  logic                  DonexSO;
  logic                  RdEnxSO;
  logic [ADDR_W-1:0]     RdAddrxDO;
  logic [SHARES*5-1:0]   RdDataxDI;
  logic [SHARES*5-1:0]   SboxInxDO;
  logic                  SboxIotaxDO;
  logic [RAND_W-1:0]     ZxDO;
  logic [SHARES*5-1:0]   SboxOutxDI;
  logic [RAND_W-1:0]     RandxDI;
  logic                  RandValidxSI;
  logic                  RandReadyxSO;
  logic                  WrEnxSO;
  logic [ADDR_W-1:0]     WrAddrxDO;
  logic [SHARES*5-1:0]   WrDataxDO;

  modport master (
    input  StartxSI, RcxDI, RdDataxDI, SboxOutxDI, RandxDI, RandValidxSI,
    output BusyxSO, DonexSO, RdEnxSO, RdAddrxDO, SboxInxDO, SboxIotaxDO, ZxDO,
           RandReadyxSO, WrEnxSO, WrAddrxDO, WrDataxDO
  );

  modport slave (
    output StartxSI, RcxDI, RdDataxDI, SboxOutxDI, RandxDI, RandValidxSI,
    input  BusyxSO, DonexSO, RdEnxSO, RdAddrxDO, SboxInxDO, SboxIotaxDO, ZxDO,
           RandReadyxSO, WrEnxSO, WrAddrxDO, WrDataxDO
  );
endinterface

// File: rtl/keccak_chi_sched.sv
// Streams every masked row of the Keccak state through one shared DOM chi S-box,
// pairing each row with fresh PRNG output and writing the result back in place.
module keccak_chi_sched #(
  parameter int SHARES   = 2,
  parameter int LANE_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int SBOX_LAT = 1
) (
  input logic               ClkxCI,
  input logic               RstxRI,
  keccak_chi_sched_if.master bus
);
  localparam int ROWS   = 5*LANE_W;
  localparam int WORD_W = SHARES*5;
  localparam int RAND_W = (SHARES*SHARES-SHARES)/2*5;
  localparam int Z_W    = (LANE_W > 1) ? $clog2(LANE_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              r_state;
  logic [LANE_W-1:0]   r_rc;
  logic [ADDR_W-1:0]   r_rdAddr;
  logic [ADDR_W-1:0]   r_wrCount;
  logic                r_rdPending;
  logic [ADDR_W-1:0]   r_pendAddr;
  logic                r_holdValid;
  logic [WORD_W-1:0]   r_holdData;
  logic [ADDR_W-1:0]   r_holdAddr;
  logic [SBOX_LAT-1:0] r_trkValid;
  logic [ADDR_W-1:0]   r_trkAddr [SBOX_LAT];

  logic                w_availValid;
  logic [WORD_W-1:0]   w_availData;
  logic [ADDR_W-1:0]   w_availAddr;
  logic                w_issue;
  logic                w_rdEn;
  logic                w_lastRead;
  logic                w_wrEn;
  logic                w_done;
  logic                w_iota;

  // A row is available straight off the RAM port the cycle after its read, else from the hold.
  assign w_availValid = r_holdValid | r_rdPending;
  assign w_availData  = r_holdValid ? r_holdData : bus.RdDataxDI;
  assign w_availAddr  = r_holdValid ? r_holdAddr : r_pendAddr;
  assign w_issue      = w_availValid & bus.RandValidxSI;

  // Only read when nothing else would be left waiting, so at most one row is ever buffered.
  assign w_rdEn     = (r_state == RUN) & (~w_availValid | w_issue);
  assign w_lastRead = w_rdEn & (r_rdAddr == ADDR_W'(ROWS-1));
  assign w_wrEn     = r_trkValid[SBOX_LAT-1];
  assign w_done     = w_wrEn & (r_wrCount == ADDR_W'(ROWS-1));
  assign w_iota     = (w_availAddr < ADDR_W'(LANE_W)) ? r_rc[w_availAddr[Z_W-1:0]] : 1'b0;

  always_comb begin
    bus.BusyxSO      = (r_state != IDLE);
    bus.DonexSO      = w_done;
    bus.RdEnxSO      = w_rdEn;
    bus.RdAddrxDO    = w_rdEn ? r_rdAddr : '0;
    bus.RandReadyxSO = w_issue;
    bus.SboxInxDO    = w_issue ? w_availData : '0;
    bus.SboxIotaxDO  = w_issue & w_iota;
    bus.ZxDO         = w_issue ? bus.RandxDI : '0;
    bus.WrEnxSO      = w_wrEn;
    bus.WrAddrxDO    = w_wrEn ? r_trkAddr[SBOX_LAT-1] : '0;
    bus.WrDataxDO    = w_wrEn ? bus.SboxOutxDI : '0;
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      r_state     <= IDLE;
      r_rc        <= '0;
      r_rdAddr    <= '0;
      r_wrCount   <= '0;
      r_rdPending <= 1'b0;
      r_pendAddr  <= '0;
      r_holdValid <= 1'b0;
      r_holdData  <= '0;
      r_holdAddr  <= '0;
      r_trkValid  <= '0;
      for (int i = 0; i < SBOX_LAT; i++) r_trkAddr[i] <= '0;
    end else begin
      r_rdPending <= w_rdEn;
      r_pendAddr  <= r_rdAddr;
      if (r_rdPending && !w_issue) begin
        r_holdValid <= 1'b1;
        r_holdData  <= bus.RdDataxDI;
        r_holdAddr  <= r_pendAddr;
      end else if (r_holdValid && w_issue) begin
        r_holdValid <= 1'b0;
      end
      if (w_rdEn) r_rdAddr <= r_rdAddr + 1'b1;
      if (w_wrEn) r_wrCount <= r_wrCount + 1'b1;

      // Tracker mirrors the S-box pipeline so each result lands on the address it came from.
      r_trkValid[0] <= w_issue;
      r_trkAddr[0]  <= w_availAddr;
      for (int i = 1; i < SBOX_LAT; i++) begin
        r_trkValid[i] <= r_trkValid[i-1];
        r_trkAddr[i]  <= r_trkAddr[i-1];
      end

      case (r_state)
        IDLE: begin
          if (bus.StartxSI) begin
            r_rc      <= bus.RcxDI;
            r_rdAddr  <= '0;
            r_wrCount <= '0;
            r_state   <= RUN;
          end
        end
        RUN:     if (w_lastRead) r_state <= DRAIN;
        DRAIN:   if (w_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
